// File: rtl/ex_ctrl_skid_pkg.sv
// Shared constants for the execute-control skid buffer: ALU op encodings,
// control-bundle field widths and the packed bundle width helper.
package ex_ctrl_skid_pkg;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam int ALUOP_W    = 2;
    localparam int ALUSRC_W   = 1;
    localparam int REGWRITE_W = 1;
    localparam int RD_W_DEF   = 5;
    localparam int FN_W_DEF   = 10;

    // Packed layout, MSB first: {ALUOp, ALUSrc, RegWrite, rd, funct}
    function automatic int bundle_w(input int rd_w, input int fn_w);
        return ALUOP_W + ALUSRC_W + REGWRITE_W + rd_w + fn_w;
    endfunction

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_IN   = 2'd1,
        SRC_SKID = 2'd2
    } main_src_e;

endpackage

// File: rtl/ctrl_bundle_reg.sv
// Enable-loaded, asynchronously reset register holding one packed control bundle.
module ctrl_bundle_reg #(
    parameter int W = 19
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] bundle_q;
    logic [W-1:0] bundle_d;

    always_comb begin
        bundle_d = bundle_q;
        if (en_i) begin
            bundle_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign q_o = bundle_q;

endmodule

// File: rtl/ex_ctrl_skid.sv
// Two-entry (main + skid) register slice between decoder and execute control.
// Optional back-pressure counter enabled by defining EX_CTRL_STALL_CNT_EN.
module ex_ctrl_skid
    import ex_ctrl_skid_pkg::*;
#(
    parameter int RD_W = RD_W_DEF,
    parameter int FN_W = FN_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      ALUOp_i,
    input  logic            ALUSrc_i,
    input  logic            RegWrite_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic [FN_W-1:0] funct_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [1:0]      ALUOp_o,
    output logic            ALUSrc_o,
    output logic            RegWrite_o,
    output logic [RD_W-1:0] rd_o,
    output logic [FN_W-1:0] funct_o
`ifdef EX_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt_o
`endif
);

    localparam int BW = bundle_w(RD_W, FN_W);

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          accept, drain;
    logic          main_load, skid_load;
    main_src_e     main_src;
    logic [BW-1:0] in_bundle;
    logic [BW-1:0] main_bundle_in;
    logic [BW-1:0] main_bundle;
    logic [BW-1:0] skid_bundle;

    // Writes to x0 are squashed at capture so neither entry ever holds one
    assign in_bundle = {ALUOp_i, ALUSrc_i, RegWrite_i && (rd_i != '0), rd_i, funct_i};

    assign accept = in_valid_i && in_ready_q;
    assign drain  = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_src     = SRC_HOLD;
        skid_load    = 1'b0;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Skid is older than anything arriving, so it refills main first
            if (skid_valid_q) begin
                main_src     = SRC_SKID;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_src     = SRC_IN;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    assign main_load      = (main_src != SRC_HOLD);
    assign main_bundle_in = (main_src == SRC_SKID) ? skid_bundle : in_bundle;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    ctrl_bundle_reg #(.W(BW)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (main_load),
        .d_i   (main_bundle_in),
        .q_o   (main_bundle)
    );

    ctrl_bundle_reg #(.W(BW)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (skid_load),
        .d_i   (in_bundle),
        .q_o   (skid_bundle)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign {ALUOp_o, ALUSrc_o, RegWrite_o, rd_o, funct_o} = main_bundle;

`ifdef EX_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating; flush deliberately leaves the count alone
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/ex_ctrl_skid.md
EX_CTRL_SKID -- requirements
Module: ex_ctrl_skid

Interface
REQ-001 Parameter: RD_W, default 5, destination-register index width.
REQ-002 Parameter: FN_W, default 10, funct field width ({funct7, funct3}).
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 in_valid_i  input  1  decoder bundle valid.
REQ-006 in_ready_o  output  1  block can accept a bundle this cycle.
REQ-007 ALUOp_i  input  2  ALU operation class from the decoder.
REQ-008 ALUSrc_i  input  1  operand-B select (1 = immediate).
REQ-009 RegWrite_i  input  1  writeback enable.
REQ-010 rd_i  input  RD_W  destination register index.
REQ-011 funct_i  input  FN_W  funct bits forwarded to ALU control.
REQ-012 flush_i  input  1  discard all held and incoming bundles.
REQ-013 out_valid_o  output  1  execute-side bundle valid.
REQ-014 out_ready_i  input  1  execute stage accepts the bundle.
REQ-015 ALUOp_o / ALUSrc_o / RegWrite_o / rd_o / funct_o  outputs  2/1/1/RD_W/FN_W  held bundle.
REQ-016 stall_cnt_o  output  16  back-pressure cycle count (present only per REQ-033).

Function
REQ-017 SHALL hold two entries, main and skid, each one bundle plus a valid bit.
REQ-018 Input handshake: transfer when in_valid_i && in_ready_o. Output handshake: transfer when out_valid_o && out_ready_i.
REQ-019 in_ready_o SHALL be driven directly from a flop, equal to NOT skid-valid; it SHALL NOT depend combinationally on out_ready_i.
REQ-020 Outputs SHALL always present the main entry; out_valid_o = main-valid.
REQ-021 Latency: a bundle accepted at edge N SHALL appear on the outputs after edge N when main is empty or drains at edge N.
REQ-022 Sustained in_valid_i=1 and out_ready_i=1 SHALL give one bundle per cycle with no bubbles.
REQ-023 Accept while main is held (out_ready_i=0): the bundle SHALL go to skid, and in_ready_o SHALL be 0 from the next cycle.
REQ-024 Main drains while skid is valid: skid SHALL move to main, skid SHALL clear, and in_ready_o SHALL return to 1 next cycle.
REQ-025 Simultaneous accept and drain with skid empty: the new bundle SHALL replace main.
REQ-026 Ordering SHALL be strict FIFO. No bundle SHALL be dropped or duplicated unless flushed.
REQ-027 x0 suppression: a bundle captured with rd_i == 0 SHALL store RegWrite as 0.
REQ-028 flush_i=1 at an edge SHALL clear both valid bits. An input offered in the same cycle SHALL be discarded. in_ready_o SHALL be 1 next cycle. flush_i takes priority over all handshakes.
REQ-029 Payload registers SHALL load only on capture. Payload values while invalid are don't-care, but SHALL be deterministic.

Reset
REQ-030 While rst_i=0 (asynchronous): main/skid valid = 0, out_valid_o = 0, in_ready_o = 1, all payload outputs = 0, stall_cnt_o = 0.
REQ-031 Reset asserted mid-transfer SHALL discard all held bundles. After release, the first accepted bundle SHALL follow REQ-021.

Configuration
REQ-032 Macro EX_CTRL_STALL_CNT_EN controls the stall counter.
REQ-033 With EX_CTRL_STALL_CNT_EN defined:
- stall_cnt_o SHALL increment each cycle with out_valid_o=1 and out_ready_i=0.
- It SHALL saturate at 16'hFFFF.
- It SHALL be cleared only by reset; flush SHALL NOT clear it.
REQ-034 Without the macro, the stall_cnt_o port and its logic SHALL be absent.

Structure
REQ-035 The shared constants include (Const.v) SHALL hold:
- ALU_OP_* encodings;
- the control-bundle field widths;
- a bundle-width macro for packing.
REQ-036 One sub-module, ctrl_bundle_reg (enable-loaded, async-reset, bundle-wide register), SHALL be instantiated twice: main and skid.

Verification
REQ-037 Reset: hold rst_i=0 for 3 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, all outputs 0.
REQ-038 Streaming: 8 back-to-back bundles (ALUOp=2'b10, rd=1..8) with out_ready_i=1 -> rd_o = 1..8 on consecutive cycles, 1-cycle latency.
REQ-039 Back-pressure: out_ready_i=0 after bundle rd=3 with bundles rd=4,5 offered -> rd=4 held in skid, in_ready_o=0. Release -> rd_o sequence 3,4,5 with none lost; stall_cnt_o equals the held cycles (macro on).
REQ-040 Flush with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the offered bundle never appears.
REQ-041 x0: bundle RegWrite_i=1, rd_i=0 -> RegWrite_o=0. Bundle RegWrite_i=1, rd_i=7 -> RegWrite_o=1.
REQ-042 Async reset: assert rst_i mid-clock with skid full -> outputs clear immediately without a clock edge.
